// File: rtl/instr_fetch_pkg.sv
// Shared fetch/decode definitions: opcodes,
// instruction field layout and fetch FSM encoding.
package instr_fetch_pkg;

    localparam int OP_W    = 3;
    localparam int OPR_W   = 2;
    localparam int INSTR_W = OP_W + 2 * OPR_W;

    localparam int OPR2_LSB = 0;
    localparam int OPR1_LSB = OPR_W;
    localparam int OP_LSB   = 2 * OPR_W;

    localparam logic [OP_W-1:0] OP_NOOP  = 3'b000;
    localparam logic [OP_W-1:0] OP_SET   = 3'b001;
    localparam logic [OP_W-1:0] OP_INC   = 3'b010;
    localparam logic [OP_W-1:0] OP_DEC   = 3'b011;
    localparam logic [OP_W-1:0] OP_LOAD  = 3'b100;
    localparam logic [OP_W-1:0] OP_STORE = 3'b101;
    localparam logic [OP_W-1:0] OP_ADD   = 3'b110;
    localparam logic [OP_W-1:0] OP_COPY  = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_ISSUE = 3'd3,
        S_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch unit bus: run control, program ROM port
// and decoded instruction fields.
interface instr_fetch_if #(
    parameter int SIZE   = 4,
    parameter int ADDR_W = 4
);
    logic              start;
    logic [ADDR_W:0]   prog_len;
    logic              stall;
    logic [2*SIZE-2:0] rom_data;
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [SIZE-2:0]   op_code;
    logic [SIZE-3:0]   Opr1;
    logic [SIZE-3:0]   Opr2;
    logic              instr_valid;
    logic              busy;
    logic              done;

    modport master (
        input  start, prog_len, stall, rom_data,
        output rom_en, rom_addr, op_code,
        output Opr1, Opr2, instr_valid,
        output busy, done
    );

    modport slave (
        output start, prog_len, stall, rom_data,
        input  rom_en, rom_addr, op_code,
        input  Opr1, Opr2, instr_valid,
        input  busy, done
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC, instruction register
// and FETCH/LATCH/ISSUE sequencer over a sync ROM.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int SIZE   = 4,
    parameter int ADDR_W = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    instr_fetch_if.master bus
);

    localparam int IW = 2 * SIZE - 1;

    state_e            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] last;
    logic [IW-1:0]     ir;
    logic              rom_en_q;
    logic              valid_q;
    logic              busy_q;
    logic              done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pc       <= '0;
            last     <= '0;
            ir       <= '0;
            rom_en_q <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        pc   <= '0;
                        last <= bus.prog_len[ADDR_W-1:0]
                              - ADDR_W'(1);
                        if (bus.prog_len != '0) begin
                            state    <= S_FETCH;
                            rom_en_q <= 1'b1;
                            busy_q   <= 1'b1;
                            done_q   <= 1'b0;
                        end else begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    state    <= S_LATCH;
                    rom_en_q <= 1'b0;
                end
                S_LATCH: begin
                    ir      <= bus.rom_data;
                    valid_q <= 1'b1;
                    state   <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (!bus.stall) begin
                        valid_q <= 1'b0;
                        // last is prog_len-1, so a full ROM ends at the top address
                        if (pc == last) begin
                            state  <= S_DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            pc       <= pc + ADDR_W'(1);
                            rom_en_q <= 1'b1;
                            state    <= S_FETCH;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Fields read as NOOP/zero whenever nothing is issued
    assign bus.op_code = valid_q
        ? ir[OP_LSB +: SIZE-1] : '0;
    assign bus.Opr1 = valid_q
        ? ir[OPR1_LSB +: SIZE-2] : '0;
    assign bus.Opr2 = valid_q
        ? ir[OPR2_LSB +: SIZE-2] : '0;

    assign bus.instr_valid = valid_q;
    assign bus.rom_en      = rom_en_q;
    assign bus.rom_addr    = pc;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with ROM model
// and an issue scoreboard.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_if #(.SIZE(4), .ADDR_W(4)) bus ();

    instr_fetch #(.SIZE(4), .ADDR_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [6:0] rom [16];
    always @(posedge clk)
        if (bus.rom_en) bus.rom_data <= rom[bus.rom_addr];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int issue_cnt = 0;
    int rom_en_cnt = 0;
    int hold_cnt = 0;
    int last_issue = -1;
    bit spacing_on = 1'b0;
    int reads [16];
    logic [6:0] sb_q [$];
    int hold_q [$];

    always @(posedge clk) cyc++;

    task automatic check(string tag,
                         logic [31:0] obs,
                         logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    // Monitor: pops one expected word per unstalled issue
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rom_en) begin
                reads[bus.rom_addr]++;
                rom_en_cnt++;
            end
            if (bus.instr_valid) begin
                hold_cnt++;
                check("issue_expected",
                      32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    check("issue_word",
                          {bus.op_code, bus.Opr1, bus.Opr2},
                          sb_q[0]);
                    if (!bus.stall) begin
                        void'(sb_q.pop_front());
                        issue_cnt++;
                        hold_q.push_back(hold_cnt);
                        hold_cnt = 0;
                        if (spacing_on && last_issue >= 0)
                            check("issue_spacing",
                                  cyc - last_issue, 3);
                        last_issue = cyc;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 16; i++) reads[i] = 0;
        hold_q.delete();
        hold_cnt = 0;
        last_issue = -1;
    endtask

    task automatic start_run(int len);
        for (int i = 0; i < len; i++) sb_q.push_back(rom[i]);
        bus.prog_len = 5'(len);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(int max, output int c);
        c = -1;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (bus.done) begin
                c = cyc;
                return;
            end
        end
        check("done_timeout", 32'(bus.done), 32'd1);
    endtask

    initial begin
        int base;
        int rbase;
        int dc;
        bus.start = 1'b0;
        bus.stall = 1'b0;
        bus.prog_len = '0;
        for (int i = 0; i < 16; i++) rom[i] = '0;

        // Reset state
        do_reset();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_rom_en", 32'(bus.rom_en), 32'd0);
        check("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
        check("rst_op", 32'(bus.op_code), 32'd0);

        // Three-instruction run
        clear_stats();
        spacing_on = 1'b1;
        rom[0] = {OP_ADD, 2'b01, 2'b10};
        rom[1] = {OP_INC, 2'b00, 2'b00};
        rom[2] = {OP_STORE, 2'b01, 2'b00};
        base = issue_cnt;
        rbase = rom_en_cnt;
        start_run(3);
        check("t1_busy", 32'(bus.busy), 32'd1);
        wait_done(40, dc);
        check("t1_issues", issue_cnt - base, 3);
        check("t1_done_lat", dc - last_issue, 1);
        check("t1_reads", rom_en_cnt - rbase, 3);
        check("t1_busy_end", 32'(bus.busy), 32'd0);
        check("t1_sb_empty", sb_q.size(), 0);
        for (int i = 0; i < 3; i++)
            check("t1_hold", hold_q[i], 1);

        // Empty program straight after reset
        do_reset();
        clear_stats();
        base = issue_cnt;
        rbase = rom_en_cnt;
        start_run(0);
        check("t2_done", 32'(bus.done), 32'd1);
        check("t2_busy", 32'(bus.busy), 32'd0);
        repeat (3) step();
        check("t2_rom_en", rom_en_cnt - rbase, 0);
        check("t2_issues", issue_cnt - base, 0);
        check("t2_done_hold", 32'(bus.done), 32'd1);

        // Stall the first issue for four cycles
        clear_stats();
        spacing_on = 1'b0;
        rom[0] = {OP_SET, 2'b10, 2'b01};
        rom[1] = {OP_COPY, 2'b11, 2'b00};
        base = issue_cnt;
        start_run(2);
        for (int i = 0; i < 10 && !bus.instr_valid; i++)
            step();
        check("t3_valid", 32'(bus.instr_valid), 32'd1);
        bus.stall = 1'b1;
        repeat (4) step();
        check("t3_pc_held", 32'(bus.rom_addr), 32'd0);
        check("t3_op_held", 32'(bus.op_code), 32'(OP_SET));
        bus.stall = 1'b0;
        wait_done(40, dc);
        check("t3_issues", issue_cnt - base, 2);
        check("t3_hold0", hold_q[0], 5);
        check("t3_hold1", hold_q[1], 1);
        check("t3_reads0", reads[0], 1);
        check("t3_reads1", reads[1], 1);

        // Start pulsed while busy is ignored
        clear_stats();
        spacing_on = 1'b1;
        rom[0] = {OP_LOAD, 2'b01, 2'b11};
        rom[1] = {OP_DEC, 2'b10, 2'b00};
        rom[2] = {OP_ADD, 2'b11, 2'b01};
        rom[3] = {OP_NOOP, 2'b01, 2'b01};
        base = issue_cnt;
        start_run(4);
        step();
        bus.start = 1'b1;
        bus.prog_len = 5'd1;
        step();
        bus.start = 1'b0;
        wait_done(60, dc);
        check("t4_issues", issue_cnt - base, 4);
        check("t4_pc_end", 32'(bus.rom_addr), 32'd3);
        check("t4_sb_empty", sb_q.size(), 0);
        for (int i = 0; i < 4; i++)
            check("t4_reads", reads[i], 1);

        // Reset during the second issue
        clear_stats();
        base = issue_cnt;
        start_run(3);
        for (int i = 0; i < 20; i++) begin
            if (bus.instr_valid && issue_cnt == base + 1)
                break;
            step();
        end
        check("t5_in_issue2", 32'(bus.instr_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_op", 32'(bus.op_code), 32'd0);
        check("t5_valid", 32'(bus.instr_valid), 32'd0);
        check("t5_busy", 32'(bus.busy), 32'd0);
        check("t5_rom_addr", 32'(bus.rom_addr), 32'd0);
        sb_q.delete();
        step();
        rst_n = 1'b1;
        base = issue_cnt;
        repeat (6) step();
        check("t5_idle_busy", 32'(bus.busy), 32'd0);
        check("t5_idle_done", 32'(bus.done), 32'd0);
        check("t5_no_issue", issue_cnt - base, 0);

        // Full 16-entry program, no wrap
        clear_stats();
        for (int i = 0; i < 16; i++) rom[i] = 7'(i * 7 + 1);
        base = issue_cnt;
        rbase = rom_en_cnt;
        start_run(16);
        wait_done(100, dc);
        check("t6_issues", issue_cnt - base, 16);
        check("t6_pc_end", 32'(bus.rom_addr), 32'd15);
        for (int i = 0; i < 16; i++)
            check("t6_reads", reads[i], 1);
        repeat (3) step();
        check("t6_no_wrap", rom_en_cnt - rbase, 16);
        check("t6_done", 32'(bus.done), 32'd1);

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
